// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared register-width and pipeline-stage record definitions
//
// Purpose: common types for the destination-tracking pipeline and the forwarding unit.
//   RW      register-address width (16 architectural registers)
//   dest_t  one stage record {rd, rf_enable, load}
//   BUBBLE  empty stage record; rf_enable=0 so it never matches a source compare
package hazard_pkg;

   localparam int RW = 4;

   typedef struct packed {
      logic [RW-1:0] rd;
      logic          rf_enable;
      logic          load;
   } dest_t;

   localparam dest_t BUBBLE = '{rd: '0, rf_enable: 1'b0, load: 1'b0};

endpackage

// File: rtl/pipe_dest_stage.sv
// rtl/pipe_dest_stage.sv - one registered {rd, rf_enable, load} pipeline stage
//
// Purpose: holds the destination record of the instruction occupying one stage.
// Ports:
//   clk     in   pipeline clock
//   reset   in   asynchronous, active-high; empties the stage
//   bubble  in   replace the incoming record with an empty one on this edge
//   d       in   record arriving from the previous stage
//   q       out  record of the instruction in this stage
module pipe_dest_stage
   import hazard_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  bubble,
   input  dest_t d,
   output dest_t q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= BUBBLE;
      else if (bubble)
         q <= BUBBLE;
      else
         q <= d;
   end

endmodule

// File: rtl/hazard_dest_pipeline.sv
// rtl/hazard_dest_pipeline.sv - EX/MEM/WB destination tracking with load-use stall detection
//
// Purpose: carries each in-flight instruction's destination register, RF write enable and
// load flag through EX, MEM and WB for the forwarding unit; detects load-use hazards, stalls
// IF/ID for one cycle while inserting a bubble into EX, and counts stall cycles (saturating).
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   ID_Rd, ID_RF_enable             destination / write enable of the instruction in ID
//   ID_load_instr                   instruction in ID is a load
//   ID_Rn, ID_Rm                    source registers of the instruction in ID
//   ID_use_Rn, ID_use_Rm            qualify the source compares
//   flush                           taken branch; ID instruction must not enter EX
//   EX_/MEM_/WB_Rd, _RF_enable      per-stage destination records
//   EX_load                         instruction in EX is a load
//   stall                           combinational; hold PC and IF/ID this cycle
//   stall_count                     saturating count of stall cycles
module hazard_dest_pipeline
   import hazard_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RW-1:0]    ID_Rd,
   input  logic             ID_RF_enable,
   input  logic             ID_load_instr,
   input  logic [RW-1:0]    ID_Rn,
   input  logic [RW-1:0]    ID_Rm,
   input  logic             ID_use_Rn,
   input  logic             ID_use_Rm,
   input  logic             flush,
   output logic [RW-1:0]    EX_Rd,
   output logic [RW-1:0]    MEM_Rd,
   output logic [RW-1:0]    WB_Rd,
   output logic             EX_RF_enable,
   output logic             MEM_RF_enable,
   output logic             WB_RF_enable,
   output logic             EX_load,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dest_t id_rec;
   dest_t ex_q;
   dest_t mem_q;
   dest_t wb_q;
   logic  raw;
   logic  ex_bubble;

   assign id_rec = '{rd: ID_Rd, rf_enable: ID_RF_enable, load: ID_load_instr};

   // The use_* qualifiers gate each compare, so an unused source field can never stall.
   // A bubble in EX has rf_enable=0, so its rd=0 cannot match R0 sources either.
   always_comb begin
      raw = 1'b0;
      if (ex_q.load && ex_q.rf_enable)
         raw = (ID_use_Rn && (ID_Rn == ex_q.rd)) || (ID_use_Rm && (ID_Rm == ex_q.rd));
   end

   // The ID instruction is killed by a flush, so there is nothing to stall for.
   assign stall     = raw && !flush;
   assign ex_bubble = flush || stall;

   pipe_dest_stage u_ex (
      .clk    (clk),
      .reset  (reset),
      .bubble (ex_bubble),
      .d      (id_rec),
      .q      (ex_q)
   );

   pipe_dest_stage u_mem (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .d      (ex_q),
      .q      (mem_q)
   );

   pipe_dest_stage u_wb (
      .clk    (clk),
      .reset  (reset),
      .bubble (1'b0),
      .d      (mem_q),
      .q      (wb_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count <= '0;
      else if (stall && (stall_count != CNT_MAX))
         stall_count <= stall_count + 1'b1;
   end

   assign EX_Rd         = ex_q.rd;
   assign EX_RF_enable  = ex_q.rf_enable;
   assign EX_load       = ex_q.load;
   assign MEM_Rd        = mem_q.rd;
   assign MEM_RF_enable = mem_q.rf_enable;
   assign WB_Rd         = wb_q.rd;
   assign WB_RF_enable  = wb_q.rf_enable;

   // Load data is resolved by forwarding once past EX, so the flag is not consumed later.
   logic unused_load_flags;
   assign unused_load_flags = &{1'b0, mem_q.load, wb_q.load};

endmodule

// File: tb/tb_hazard_dest_pipeline.sv
// tb/tb_hazard_dest_pipeline.sv - randomized self-checking bench for hazard_dest_pipeline
module tb_hazard_dest_pipeline;

   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    ID_Rd, ID_Rn, ID_Rm;
   logic          ID_RF_enable, ID_load_instr, ID_use_Rn, ID_use_Rm, flush;
   logic [3:0]    EX_Rd, MEM_Rd, WB_Rd;
   logic          EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load, stall;
   logic [CW-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int rd;
      bit en;
      bit ld;
   } rec_t;

   // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
   rec_t pipe[$];
   int   m_cnt;

   hazard_dest_pipeline #(.CNT_W(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .ID_Rd         (ID_Rd),
      .ID_RF_enable  (ID_RF_enable),
      .ID_load_instr (ID_load_instr),
      .ID_Rn         (ID_Rn),
      .ID_Rm         (ID_Rm),
      .ID_use_Rn     (ID_use_Rn),
      .ID_use_Rm     (ID_use_Rm),
      .flush         (flush),
      .EX_Rd         (EX_Rd),
      .MEM_Rd        (MEM_Rd),
      .WB_Rd         (WB_Rd),
      .EX_RF_enable  (EX_RF_enable),
      .MEM_RF_enable (MEM_RF_enable),
      .WB_RF_enable  (WB_RF_enable),
      .EX_load       (EX_load),
      .stall         (stall),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      rec_t e = '{rd: 0, en: 0, ld: 0};
      pipe = {e, e, e};
      m_cnt = 0;
   endfunction

   // A load in EX blocks any ID instruction that genuinely reads its destination,
   // unless that ID instruction is being flushed anyway.
   function automatic bit model_stall();
      bit hit = 0;
      if (pipe[0].ld && pipe[0].en) begin
         if (ID_use_Rn && int'(ID_Rn) == pipe[0].rd) hit = 1;
         if (ID_use_Rm && int'(ID_Rm) == pipe[0].rd) hit = 1;
      end
      return hit && !flush;
   endfunction

   task automatic check_model();
      check("stall",       stall,         model_stall());
      check("stall_count", stall_count,   m_cnt);
      check("ex_rd",       EX_Rd,         pipe[0].rd);
      check("ex_en",       EX_RF_enable,  pipe[0].en);
      check("ex_load",     EX_load,       pipe[0].ld);
      check("mem_rd",      MEM_Rd,        pipe[1].rd);
      check("mem_en",      MEM_RF_enable, pipe[1].en);
      check("wb_rd",       WB_Rd,         pipe[2].rd);
      check("wb_en",       WB_RF_enable,  pipe[2].en);
   endtask

   task automatic set_in(input int rd, input bit en, input bit ld, input int rn, input bit urn,
                         input int rm, input bit urm, input bit fl);
      ID_Rd = 4'(rd); ID_RF_enable = en; ID_load_instr = ld;
      ID_Rn = 4'(rn); ID_use_Rn = urn;
      ID_Rm = 4'(rm); ID_use_Rm = urm;
      flush = fl;
   endtask

   // Advance one clock; the model retires WB and admits ID (or a bubble) into EX.
   task automatic tick();
      bit   st = model_stall();
      rec_t nx;
      @(posedge clk);
      if (flush || st) nx = '{rd: 0, en: 0, ld: 0};
      else             nx = '{rd: int'(ID_Rd), en: ID_RF_enable, ld: ID_load_instr};
      void'(pipe.pop_back());
      pipe.push_front(nx);
      if (st && m_cnt < CMAX) m_cnt++;
      @(negedge clk);
   endtask

   task automatic step(input int rd, input bit en, input bit ld, input int rn, input bit urn,
                       input int rm, input bit urm, input bit fl);
      set_in(rd, en, ld, rn, urn, rm, urm, fl);
      #1;
      check_model();
      tick();
   endtask

   task automatic async_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_model();
      check("rst_stall", stall, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_model();
      check("reset_count", stall_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // Propagation of three plain writers.
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(2, 1, 0, 0, 0, 0, 0, 0);
      step(3, 1, 0, 0, 0, 0, 0, 0);
      #1;
      check("prop_wb_rd", WB_Rd, 1);
      check("prop_mem_rd", MEM_Rd, 2);
      check("prop_ex_rd", EX_Rd, 3);
      check("prop_ens", {WB_RF_enable, MEM_RF_enable, EX_RF_enable}, 3'b111);

      // Load-use: load R5, then a reader of R5.
      step(5, 1, 1, 0, 0, 0, 0, 0);
      set_in(7, 1, 0, 5, 1, 0, 0, 0);
      #1;
      check("lu_stall", stall, 1);
      tick();
      #1;
      check("lu_ex_bubble", EX_RF_enable, 0);
      check("lu_mem_rd", MEM_Rd, 5);
      check("lu_stall_once", stall, 0);
      check("lu_count", stall_count, 1);
      tick();

      // Unused source matching a load destination.
      step(5, 1, 1, 0, 0, 0, 0, 0);
      set_in(6, 1, 0, 1, 0, 5, 0, 0);
      #1;
      check("unused_stall", stall, 0);
      tick();
      #1;
      check("unused_no_bubble", EX_Rd, 6);

      // Flush against a live hazard.
      step(2, 1, 1, 0, 0, 0, 0, 0);
      set_in(9, 1, 0, 2, 1, 0, 0, 1);
      #1;
      check("flush_stall", stall, 0);
      tick();
      #1;
      check("flush_bubble", EX_RF_enable, 0);
      check("flush_count", stall_count, 1);

      // Reset with a load in EX, then first instruction after release.
      step(4, 1, 1, 0, 0, 0, 0, 0);
      set_in(0, 0, 0, 4, 1, 4, 1, 0);
      #2;
      async_reset();
      step(3, 1, 0, 0, 0, 0, 0, 0);
      #1;
      check("post_rst_ex_rd", EX_Rd, 3);

      // Randomized traffic with a narrow register range to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            async_reset();
         end else begin
            step($urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 7) == 0);
         end
      end

      // Saturation: twenty single-cycle load-use stalls.
      async_reset();
      for (int i = 0; i < 20; i++) begin
         step(5, 1, 1, 0, 0, 0, 0, 0);
         step(8, 1, 0, 0, 0, 5, 1, 0);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("sat_count", stall_count, CMAX);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
